// File: rtl/rv32i_exec_mem.sv
// RV32I execute/memory block: combinational decode and ALU, plus a byte-lane data memory.
// Memory writes are clocked. Reset asynchronously clears the whole array.
module rv32i_exec_mem #(
  parameter int unsigned AddrSize = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inst_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        mem_we_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] imm_o,
  output logic        arithmetic_o,
  output logic        arithmetic_imm_o,
  output logic        load_o,
  output logic        store_o,
  output logic        branch_o,
  output logic        jal_o,
  output logic        jalr_o,
  output logic        lui_o,
  output logic        auipc_o,
  output logic [31:0] alu_out_o,
  output logic [31:0] load_data_o
);

  localparam int unsigned Depth = 2 ** AddrSize;

  localparam logic [6:0] OpArith    = 7'b0110011;
  localparam logic [6:0] OpArithImm = 7'b0010011;
  localparam logic [6:0] OpLoad     = 7'b0000011;
  localparam logic [6:0] OpStore    = 7'b0100011;
  localparam logic [6:0] OpBranch   = 7'b1100011;
  localparam logic [6:0] OpJal      = 7'b1101111;
  localparam logic [6:0] OpJalr     = 7'b1100111;
  localparam logic [6:0] OpLui      = 7'b0110111;
  localparam logic [6:0] OpAuipc    = 7'b0010111;

  logic known_op;

  always_comb begin
    arithmetic_o     = 1'b0;
    arithmetic_imm_o = 1'b0;
    load_o           = 1'b0;
    store_o          = 1'b0;
    branch_o         = 1'b0;
    jal_o            = 1'b0;
    jalr_o           = 1'b0;
    lui_o            = 1'b0;
    auipc_o          = 1'b0;
    case (inst_i[6:0])
      OpArith:    arithmetic_o     = 1'b1;
      OpArithImm: arithmetic_imm_o = 1'b1;
      OpLoad:     load_o           = 1'b1;
      OpStore:    store_o          = 1'b1;
      OpBranch:   branch_o         = 1'b1;
      OpJal:      jal_o            = 1'b1;
      OpJalr:     jalr_o           = 1'b1;
      OpLui:      lui_o            = 1'b1;
      OpAuipc:    auipc_o          = 1'b1;
      default:    ;
    endcase
  end

  assign known_op = arithmetic_o | arithmetic_imm_o | load_o | store_o | branch_o |
                    jal_o | jalr_o | lui_o | auipc_o;

  assign rs1_o    = inst_i[19:15];
  assign rs2_o    = inst_i[24:20];
  assign funct3_o = inst_i[14:12];
  assign funct7_o = inst_i[31:25];
  // Formats without a destination report x0 so writeback needs no extra gating.
  assign rd_o     = (store_o || branch_o || !known_op) ? 5'd0 : inst_i[11:7];

  always_comb begin
    imm_o = '0;
    if (arithmetic_imm_o || load_o || jalr_o) begin
      imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
    end else if (store_o) begin
      imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    end else if (branch_o) begin
      imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    end else if (lui_o || auipc_o) begin
      imm_o = {inst_i[31:12], 12'b0};
    end else if (jal_o) begin
      imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end
  end

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] sra_res;

  assign op_b    = arithmetic_o ? rs2_data_i : imm_o;
  assign shamt   = op_b[4:0];
  // Kept as its own signed expression so the shift stays arithmetic.
  assign sra_res = $signed(rs1_data_i) >>> shamt;

  always_comb begin
    alu_out_o = '0;
    if (arithmetic_o || arithmetic_imm_o) begin
      case (funct3_o)
        3'd0: alu_out_o = (arithmetic_o && inst_i[30]) ? rs1_data_i - op_b : rs1_data_i + op_b;
        3'd1: alu_out_o = rs1_data_i << shamt;
        3'd2: alu_out_o = {31'b0, $signed(rs1_data_i) < $signed(op_b)};
        3'd3: alu_out_o = {31'b0, rs1_data_i < op_b};
        3'd4: alu_out_o = rs1_data_i ^ op_b;
        3'd5: alu_out_o = inst_i[30] ? sra_res : rs1_data_i >> shamt;
        3'd6: alu_out_o = rs1_data_i | op_b;
        3'd7: alu_out_o = rs1_data_i & op_b;
        default: alu_out_o = '0;
      endcase
    end else if (load_o || store_o) begin
      alu_out_o = rs1_data_i + imm_o;
    end else if (branch_o) begin
      case (funct3_o)
        3'd0: alu_out_o = {31'b0, rs1_data_i == rs2_data_i};
        3'd1: alu_out_o = {31'b0, rs1_data_i != rs2_data_i};
        3'd4: alu_out_o = {31'b0, $signed(rs1_data_i) < $signed(rs2_data_i)};
        3'd5: alu_out_o = {31'b0, $signed(rs1_data_i) >= $signed(rs2_data_i)};
        3'd6: alu_out_o = {31'b0, rs1_data_i < rs2_data_i};
        3'd7: alu_out_o = {31'b0, rs1_data_i >= rs2_data_i};
        default: alu_out_o = '0;
      endcase
    end
  end

  logic [31:0]         mem_q [Depth];
  logic [AddrSize-1:0] word_idx;
  logic [31:0]         rd_word;
  logic [31:0]         wr_data;
  logic [3:0]          wr_be;

  // Upper address bits are dropped, so accesses wrap within the array.
  assign word_idx = alu_out_o[AddrSize+1:2];
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = rs2_data_i;
    case (funct3_o)
      3'd0: begin
        wr_be   = 4'b0001 << alu_out_o[1:0];
        wr_data = {4{rs2_data_i[7:0]}};
      end
      3'd1: begin
        wr_be   = alu_out_o[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{rs2_data_i[15:0]}};
      end
      3'd2: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_i && store_o) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte     = rd_word[8*alu_out_o[1:0] +: 8];
    ld_half     = alu_out_o[1] ? rd_word[31:16] : rd_word[15:0];
    load_data_o = '0;
    if (load_o) begin
      case (funct3_o)
        3'd0: load_data_o = {{24{ld_byte[7]}}, ld_byte};
        3'd1: load_data_o = {{16{ld_half[15]}}, ld_half};
        3'd2: load_data_o = rd_word;
        3'd4: load_data_o = {24'b0, ld_byte};
        3'd5: load_data_o = {16'b0, ld_half};
        default: load_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_exec_mem.sv
// Self-checking bench for rv32i_exec_mem: directed cases plus randomized traffic against a
// byte-addressed behavioural model.
module tb_rv32i_exec_mem;

  localparam int unsigned AddrSize = 10;
  localparam int unsigned MemBytes = 4 << AddrSize;

  logic        clk, rst_n;
  logic [31:0] inst, rs1_data, rs2_data;
  logic        mem_we;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm, alu_out, load_data;
  logic        arithmetic, arithmetic_imm, load, store, branch, jal, jalr, lui, auipc;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mem_m [MemBytes];

  rv32i_exec_mem #(.AddrSize(AddrSize)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .inst_i          (inst),
    .rs1_data_i      (rs1_data),
    .rs2_data_i      (rs2_data),
    .mem_we_i        (mem_we),
    .rs1_o           (rs1),
    .rs2_o           (rs2),
    .rd_o            (rd),
    .funct3_o        (funct3),
    .funct7_o        (funct7),
    .imm_o           (imm),
    .arithmetic_o    (arithmetic),
    .arithmetic_imm_o(arithmetic_imm),
    .load_o          (load),
    .store_o         (store),
    .branch_o        (branch),
    .jal_o           (jal),
    .jalr_o          (jalr),
    .lui_o           (lui),
    .auipc_o         (auipc),
    .alu_out_o       (alu_out),
    .load_data_o     (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [8:0] m_flags(input logic [31:0] in);
    case (in[6:0])
      7'h33:   return 9'b100000000;
      7'h13:   return 9'b010000000;
      7'h03:   return 9'b001000000;
      7'h23:   return 9'b000100000;
      7'h63:   return 9'b000010000;
      7'h6F:   return 9'b000001000;
      7'h67:   return 9'b000000100;
      7'h37:   return 9'b000000010;
      7'h17:   return 9'b000000001;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] in);
    logic [11:0] i12, s12;
    logic [12:0] b13;
    logic [20:0] j21;
    i12 = in[31:20];
    s12 = {in[31:25], in[11:7]};
    b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    j21 = {in[31], in[19:12], in[20], in[30:21], 1'b0};
    case (in[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(i12));
      7'h23:               return 32'($signed(s12));
      7'h63:               return 32'($signed(b13));
      7'h37, 7'h17:        return in & 32'hFFFF_F000;
      7'h6F:               return 32'($signed(j21));
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] in, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] iv, opb, r;
    logic [4:0]  sh;
    iv = m_imm(in);
    r  = 32'h0;
    case (in[6:0])
      7'h33, 7'h13: begin
        opb = (in[6:0] == 7'h33) ? b : iv;
        sh  = opb[4:0];
        case (in[14:12])
          3'd0: r = (in[6:0] == 7'h33 && in[30]) ? a - opb : a + opb;
          3'd1: r = a << sh;
          3'd2: r = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
          3'd3: r = (a < opb) ? 32'd1 : 32'd0;
          3'd4: r = a ^ opb;
          3'd5: if (in[30]) r = $signed(a) >>> sh; else r = a >> sh;
          3'd6: r = a | opb;
          default: r = a & opb;
        endcase
      end
      7'h03, 7'h23: r = a + iv;
      7'h63: begin
        case (in[14:12])
          3'd0: r = (a == b) ? 32'd1 : 32'd0;
          3'd1: r = (a != b) ? 32'd1 : 32'd0;
          3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd5: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
          3'd6: r = (a < b) ? 32'd1 : 32'd0;
          3'd7: r = (a >= b) ? 32'd1 : 32'd0;
          default: r = 32'd0;
        endcase
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] in, input logic [31:0] a);
    int unsigned ad, hb, wb;
    if (in[6:0] != 7'h03) return 32'h0;
    ad = m_alu(in, a, 32'h0) % MemBytes;
    hb = ad & ~32'd1;
    wb = ad & ~32'd3;
    case (in[14:12])
      3'd0: return 32'($signed(mem_m[ad]));
      3'd1: return 32'($signed({mem_m[hb+1], mem_m[hb]}));
      3'd2: return {mem_m[wb+3], mem_m[wb+2], mem_m[wb+1], mem_m[wb]};
      3'd4: return {24'h0, mem_m[ad]};
      3'd5: return {16'h0, mem_m[hb+1], mem_m[hb]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                         input logic we);
    int unsigned ad, hb, wb;
    if (!we || !rst_n || in[6:0] != 7'h23) return;
    ad = m_alu(in, a, b) % MemBytes;
    hb = ad & ~32'd1;
    wb = ad & ~32'd3;
    case (in[14:12])
      3'd0: mem_m[ad] = b[7:0];
      3'd1: begin mem_m[hb] = b[7:0]; mem_m[hb+1] = b[15:8]; end
      3'd2: for (int k = 0; k < 4; k++) mem_m[wb+k] = b[8*k +: 8];
      default: ;
    endcase
  endtask

  task automatic m_clear();
    for (int k = 0; k < int'(MemBytes); k++) mem_m[k] = 8'h0;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_ld(input logic [2:0] f3, input logic [11:0] i12);
    return {i12, 5'd1, f3, 5'd5, 7'h03};
  endfunction

  function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [11:0] i12);
    return {i12[11:5], 5'd2, 5'd1, f3, i12[4:0], 7'h23};
  endfunction

  task automatic drive(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                       input logic we);
    @(negedge clk);
    inst = in; rs1_data = a; rs2_data = b; mem_we = we;
    #1;
  endtask

  task automatic do_store(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                          input logic we);
    drive(in, a, b, we);
    @(posedge clk);
    #1;
    m_store(in, a, b, we);
    mem_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin @(negedge clk); rst_n = 1'b1; end
      a = $urandom();
      drive(enc_ld(3'd2, 12'($urandom_range(0, 4095))), a, 32'h0, 1'b0);
      compared++;
      if (load_data !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_load[%0d]: got %h want 00000000", i, load_data);
      end
    end
  endtask

  task automatic test_alu_directed();
    drive(32'hFFB00093, 32'h0, 32'h0, 1'b0);
    compared++;
    if ({arithmetic_imm, rd, imm, alu_out} !== {1'b1, 5'd1, 32'hFFFFFFFB, 32'hFFFFFFFB}) begin
      mismatched++;
      $display("FAIL addi: got ai=%b rd=%0d imm=%h alu=%h want 1/1/fffffffb/fffffffb",
               arithmetic_imm, rd, imm, alu_out);
    end
    drive({7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'd3, 32'd5, 1'b0);
    compared++;
    if (alu_out !== 32'hFFFFFFFE) begin
      mismatched++; $display("FAIL sub: got %h want fffffffe", alu_out);
    end
    drive({7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33}, 32'h80000000, 32'd4, 1'b0);
    compared++;
    if (alu_out !== 32'hF8000000) begin
      mismatched++; $display("FAIL sra: got %h want f8000000", alu_out);
    end
    drive({7'h00, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33}, 32'd1, 32'hFFFFFFFF, 1'b0);
    compared++;
    if (alu_out !== 32'd1) begin
      mismatched++; $display("FAIL sltu: got %h want 00000001", alu_out);
    end
  endtask

  task automatic test_mem_directed();
    do_store(enc_st(3'd2, 12'd4), 32'h100, 32'hDEADBEEF, 1'b1);
    drive(enc_ld(3'd2, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL lw: got %h want deadbeef", load_data);
    end
    drive(enc_ld(3'd0, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'hFFFFFFEF) begin
      mismatched++; $display("FAIL lb: got %h want ffffffef", load_data);
    end
    drive(enc_ld(3'd4, 12'd7), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'h000000DE) begin
      mismatched++; $display("FAIL lbu: got %h want 000000de", load_data);
    end
    drive(enc_ld(3'd1, 12'd6), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'hFFFFDEAD) begin
      mismatched++; $display("FAIL lh: got %h want ffffdead", load_data);
    end
    do_store(enc_st(3'd0, 12'd5), 32'h100, 32'h00000055, 1'b1);
    drive(enc_ld(3'd2, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'hDEAD55EF) begin
      mismatched++; $display("FAIL sb_merge: got %h want dead55ef", load_data);
    end
    do_store(enc_st(3'd0, 12'd5), 32'h100, 32'h000000AA, 1'b0);
    drive(enc_ld(3'd2, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'hDEAD55EF) begin
      mismatched++; $display("FAIL sb_no_we: got %h want dead55ef", load_data);
    end
  endtask

  task automatic test_branch_directed();
    drive(32'hFE000CE3, 32'h1234, 32'h1234, 1'b0);
    compared++;
    if ({branch, rd, imm, alu_out} !== {1'b1, 5'd0, 32'hFFFFFFF8, 32'd1}) begin
      mismatched++;
      $display("FAIL beq: got br=%b rd=%0d imm=%h alu=%h want 1/0/fffffff8/00000001",
               branch, rd, imm, alu_out);
    end
    drive(32'hFE001CE3, 32'h1234, 32'h1234, 1'b0);
    compared++;
    if (alu_out !== 32'd0) begin
      mismatched++; $display("FAIL bne: got %h want 00000000", alu_out);
    end
    drive(32'hFE007CE3, 32'h0, 32'hFFFFFFFF, 1'b0);
    compared++;
    if (alu_out !== 32'd0) begin
      mismatched++; $display("FAIL bgeu: got %h want 00000000", alu_out);
    end
  endtask

  task automatic test_async_reset();
    drive(enc_ld(3'd2, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== m_load(inst, rs1_data)) begin
      mismatched++;
      $display("FAIL pre_reset_lw: got %h want %h", load_data, m_load(inst, rs1_data));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_clear();
    #1;
    compared++;
    if (load_data !== 32'h0) begin
      mismatched++; $display("FAIL async_clear: got %h want 00000000", load_data);
    end
    do_store(enc_st(3'd2, 12'd4), 32'h100, 32'h12345678, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(enc_ld(3'd2, 12'd4), 32'h100, 32'h0, 1'b0);
    compared++;
    if (load_data !== 32'h0) begin
      mismatched++; $display("FAIL store_in_reset: got %h want 00000000", load_data);
    end
  endtask

  task automatic test_random_decode();
    logic [6:0]  ops [10];
    logic [31:0] in, a, b;
    logic [8:0]  fl;
    logic [4:0]  rd_exp;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    for (int i = 0; i < 300; i++) begin
      in = $urandom();
      in[6:0] = (i % 10 == 9) ? 7'($urandom_range(0, 127)) : ops[i % 10];
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      drive(in, a, b, 1'b0);
      fl = m_flags(in);
      rd_exp = (fl == 9'b0 || in[6:0] == 7'h23 || in[6:0] == 7'h63) ? 5'd0 : in[11:7];
      compared++;
      if ({rs1, rs2, rd, funct3, funct7, imm, arithmetic, arithmetic_imm, load, store, branch,
           jal, jalr, lui, auipc, alu_out} !==
          {in[19:15], in[24:20], rd_exp, in[14:12], in[31:25], m_imm(in), fl,
           m_alu(in, a, b)}) begin
        mismatched++;
        $display("FAIL rand_decode inst=%h a=%h b=%h: got rd=%0d imm=%h fl=%b alu=%h want rd=%0d imm=%h fl=%b alu=%h",
                 in, a, b, rd, imm, {arithmetic, arithmetic_imm, load, store, branch, jal, jalr,
                 lui, auipc}, alu_out, rd_exp, m_imm(in), fl, m_alu(in, a, b));
      end
    end
  endtask

  task automatic test_random_mem();
    logic [31:0] in, a, b;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic        we;
    for (int i = 0; i < 400; i++) begin
      f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      i12 = 12'($urandom_range(0, 63)) - 12'd16;
      a   = ($urandom() & 32'hFFFF_F000) | $urandom_range(0, 255);
      b   = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        in = enc_st(f3, i12);
        we = ($urandom_range(0, 3) != 0);
        drive(in, a, b, we);
        compared++;
        if (alu_out !== m_alu(in, a, b)) begin
          mismatched++;
          $display("FAIL rand_store_addr inst=%h: got %h want %h", in, alu_out, m_alu(in, a, b));
        end
        @(posedge clk);
        #1;
        m_store(in, a, b, we);
        mem_we = 1'b0;
      end else begin
        if (f3 == 3'd3) f3 = 3'($urandom_range(4, 5));
        in = enc_ld(f3, i12);
        drive(in, a, b, 1'b0);
        compared++;
        if (load_data !== m_load(in, a)) begin
          mismatched++;
          $display("FAIL rand_load inst=%h a=%h: got %h want %h", in, a, load_data,
                   m_load(in, a));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; inst = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; mem_we = 1'b0;
    m_clear();
    test_reset();
    test_alu_directed();
    test_mem_directed();
    test_branch_directed();
    test_async_reset();
    test_random_decode();
    test_random_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_mem.md
# rv32i_exec_mem

Combinational RV32I instruction decoder, ALU and byte-addressable data memory packaged as one block. It sits between instruction fetch and register writeback in the multi-cycle core. The core's FSM supplies the fetched instruction, the register-file operands and a memory-access strobe. The block returns decoded fields, the ALU result or branch decision, and load data.

## Interface
- `ADDR_SIZE`, default 10: log2 of data-memory depth in 32-bit words (1024 words = 4 KiB).
- `clk` input 1: clock; all memory writes occur on the rising edge.
- `rst` input 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `inst` input 32: instruction word.
- `rs1_data`, `rs2_data` input 32: register-file read values, with x0 already returning 0.
- `mem_we` input 1: memory-access-stage strobe; a store is committed only when this is 1 and `store` is 1.
- `rs1`, `rs2`, `rd` output 5: register indices.
- `funct3` output 3, `funct7` output 7: raw fields `inst[14:12]` and `inst[31:25]`.
- `imm` output 32: sign-extended immediate for the decoded format.
- `arithmetic`, `arithmetic_imm`, `load`, `store`, `branch`, `jal`, `jalr`, `lui`, `auipc` output 1 each: one-hot instruction class.
- `alu_out` output 32: ALU result, effective address, or branch-taken flag.
- `load_data` output 32: extended load result.

## Operation
- Class decode from opcode `inst[6:0]`:
  - 0110011 → arithmetic; 0010011 → arithmetic_imm; 0000011 → load; 0100011 → store; 1100011 → branch.
  - 1101111 → jal; 1100111 → jalr; 0110111 → lui; 0010111 → auipc.
  - Any other opcode: all flags 0, `imm`=0.
- Field decode:
  - `rs1`=`inst[19:15]`, `rs2`=`inst[24:20]`.
  - `rd`=`inst[11:7]`, except `rd` is forced to 0 for store, branch and unknown opcodes.
- Immediate formats:
  - I (arith_imm, load, jalr): `inst[31:20]`.
  - S: {`inst[31:25]`,`inst[11:7]`}.
  - B: {`inst[31]`,`inst[7]`,`inst[30:25]`,`inst[11:8]`,0}.
  - U (lui, auipc): {`inst[31:12]`, 12'b0}.
  - J: {`inst[31]`,`inst[19:12]`,`inst[20]`,`inst[30:21]`,0}.
  - All formats sign-extended from bit 31.
- ALU, arithmetic (operands rs1_data, rs2_data):
  - funct3 0 → ADD, or SUB when `funct7[5]`=1.
  - 1 SLL; 2 SLT (signed); 3 SLTU; 4 XOR; 5 SRL, or SRA when `funct7[5]`=1; 6 OR; 7 AND.
  - Shift amount = low 5 bits of the operand.
- ALU, arithmetic_imm: same operations with `imm` as operand B, with two differences:
  - funct3 0 is always ADD (`funct7` ignored).
  - funct3 5 uses `inst[30]` to select SRAI.
- ALU, load/store: `alu_out` = `rs1_data` + `imm`, modulo 2^32.
- ALU, branch: `alu_out` = 1 if taken, else 0.
  - funct3 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
  - funct3 2 and 3 give 0.
- ALU, all other classes: `alu_out` = 0.
- Memory organisation: 2^ADDR_SIZE words.
  - Word index = `alu_out[ADDR_SIZE+1:2]`; upper address bits are ignored, so addresses wrap.
- Stores, by funct3:
  - 0 SB: writes byte lane `alu_out[1:0]` with `rs2_data[7:0]`.
  - 1 SH: writes half `alu_out[1]` with `rs2_data[15:0]`; `alu_out[0]` is ignored.
  - 2 SW: writes the whole word; `alu_out[1:0]` are ignored.
  - Other funct3 values write nothing.
  - Unselected bytes are preserved.
- Loads (when `load`=1):
  - 0 LB and 1 LH: sign-extended.
  - 4 LBU and 5 LHU: zero-extended.
  - 2 LW: whole word.
  - Lane selection matches the stores.
  - Other funct3 values → 0.
- When `load`=0, `load_data` = 0.

## Timing
- Decoder, ALU and memory read are purely combinational: zero-cycle latency from `inst`/`rs*_data` to all outputs.
- Write: on posedge `clk` when `rst`=1, `mem_we`=1 and `store`=1.
- Read during a write cycle returns the old data before the edge and the new data after it.
- `rst`=0:
  - Immediately clears every memory word to 0, whether in idle or mid-operation.
  - Writes are inhibited while `rst` is low.
  - After release, all loads return 0 until something is stored.
- Reset value of outputs: decode and ALU outputs follow their inputs; `load_data` is 0 for any address.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093) → arithmetic_imm=1, rd=1, imm=0xFFFFFFFB, alu_out=0xFFFFFFFB.
- SUB with rs1_data=3, rs2_data=5 (funct7=0x20) → alu_out=0xFFFFFFFE. SRA of 0x80000000 by 4 → 0xF8000000. SLTU(1, 0xFFFFFFFF) → 1.
- SW at rs1_data=0x100, imm=4, rs2_data=0xDEADBEEF with mem_we pulse → LW at address 0x104 returns 0xDEADBEEF. LB at 0x104 → 0xFFFFFFEF. LBU at 0x107 → 0x000000DE. LH at 0x106 → 0xFFFFDEAD.
- SB 0x55 to 0x105 over the stored 0xDEADBEEF → LW 0x104 returns 0xDEAD55EF. Same store with mem_we=0 → unchanged.
- BEQ with equal operands, B-imm=-8 (0xFE000CE3 form) → branch=1, imm=0xFFFFFFF8, alu_out=1. BNE with equal operands → 0. BGEU(0, 0xFFFFFFFF) → 0.
- After stores, assert rst low asynchronously mid-cycle → immediate LW 0x104 returns 0. A store attempted during reset is lost.
